hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline control unit that drives the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Handles four cases: load-use hazards, taken-branch flush in ID, multi-cycle data-memory stalls, and HLT drain.
- Sits beside the decode stage. It consumes control and register-ID fields already held in the pipeline registers, and produces the enable/flush controls those registers consume.
- Outputs are Mealy (state + current inputs). Performance counters are registered.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters (saturating).
- R0_HAZARD, 0, 0 = a destination of register 0 never creates a load-use hazard; 1 = it is treated like any other register.
- DRAIN_CYC, 3, cycles spent in DRAIN before HALTED (EX, MEM, WB empty out).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- ifid_rs  in  4  source register Rs of the instruction in ID.
- ifid_rt  in  4  source register Rt of the instruction in ID.
- ifid_uses_rs  in  1  ID instruction reads Rs.
- ifid_uses_rt  in  1  ID instruction reads Rt.
- idex_memread  in  1  MemRead control bit of the instruction in EX.
- idex_rd  in  4  destination register of the instruction in EX.
- branch_taken  in  1  branch resolved taken in ID this cycle.
- halt_dec  in  1  HLT decoded in ID this cycle.
- dmem_req  in  1  EX/MEM MemRead or MemWrite asserted (MEM stage active).
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_wen  out  1  PC write enable.
- ifid_wen  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID synchronous clear.
- idex_wen  out  1  ID/EX write enable.
- idex_flush  out  1  ID/EX clear; inserts a bubble with all control bits 0.
- exmem_wen  out  1  EX/MEM write enable.
- memwb_wen  out  1  MEM/WB write enable.
- memwb_flush  out  1  MEM/WB clear; inserts a bubble.
- halted  out  1  pipeline fully drained after HLT.
- stall_cnt  out  CNT_W  total stall cycles (load-use plus memory), saturating.
- flush_cnt  out  CNT_W  total branch flushes, saturating.

Behaviour:
- **States:** RUN, LU_BUBBLE, MEM_WAIT, DRAIN, HALTED. State is 3 bits. Drain counter is 2 bits.
- **Default outputs:** all wen = 1, all flush = 0, halted = 0.
- **Hazard definitions:**
  - lu_haz = idex_memread & ((ifid_uses_rs & idex_rd==ifid_rs) | (ifid_uses_rt & idex_rd==ifid_rt)).
  - When R0_HAZARD=0, lu_haz is masked if idex_rd==0.
  - mstall = dmem_req & ~dmem_ready.
- **RUN and LU_BUBBLE** share identical output rules. Priority order:
  1. mstall: pc_wen = ifid_wen = idex_wen = exmem_wen = 0; memwb_flush = 1. Next state MEM_WAIT. stall_cnt += 1.
  2. halt_dec: pc_wen = 0; ifid_flush = 1. Next state DRAIN; drain counter loaded with 0.
  3. lu_haz: pc_wen = ifid_wen = 0; idex_flush = 1. Next state LU_BUBBLE. stall_cnt += 1.
  4. branch_taken: ifid_flush = 1. flush_cnt += 1. Next state RUN.
  5. Otherwise: defaults. Next state RUN.
- **LU_BUBBLE** lasts exactly one cycle unless rule 1 or 3 fires again. A second consecutive load-use hazard is legal: a new load now in EX re-stalls.
- **MEM_WAIT:**
  - While ~dmem_ready: same freeze as rule 1; stall_cnt += 1.
  - On dmem_ready (release cycle): evaluate rules 2–5 exactly as in RUN, then leave MEM_WAIT.
  - branch_taken and halt_dec are ignored on frozen cycles and honored only on the release cycle.
- **DRAIN:**
  - Outputs: pc_wen = 0; ifid_flush = 1; idex_flush = 1; EX/MEM and MEM/WB enables = 1.
  - mstall still freezes EX/MEM and MEM/WB as in rule 1, and the drain counter holds.
  - The drain counter increments on non-stalled cycles. On reaching DRAIN_CYC-1 with no stall, the next state is HALTED.
- **HALTED:** all wen = 0, flush = 0, halted = 1. Exit only via rst.
- **Counters:** saturate at all-ones and never wrap. Both stall and branch causes in one cycle: only the higher-priority rule takes effect and is counted.
- **Reset:**
  - While rst=1: all wen = 0, all flush = 0, halted = 0.
  - Asynchronous reset sets state = RUN and clears both counters and the drain counter.
  - Reset mid-stall or mid-drain aborts immediately. The first cycle after release is RUN with defaults.
- **Latency:** control outputs are combinational (same cycle). State and counter updates are visible the next cycle.

Test Plan:
- **Load-use:** idex_memread=1, idex_rd=5, ifid_rs=5, uses_rs=1 -> same cycle pc_wen=0, ifid_wen=0, idex_flush=1. Next cycle (idex_memread=0) defaults; stall_cnt=1.
- **R0 masking:** idex_rd=0, ifid_rt=0, uses_rt=1, R0_HAZARD=0 -> no stall, stall_cnt stays 0. Repeat with R0_HAZARD=1 -> stall.
- **Memory wait:** dmem_req=1, dmem_ready=0 for 3 cycles, branch_taken=1 throughout, then ready -> 3 frozen cycles with memwb_flush=1; stall_cnt=3; ifid_flush=1 only on the release cycle; flush_cnt=1.
- **Priority:** lu_haz and branch_taken in the same cycle -> stall only (ifid_flush=0), stall_cnt +1, flush_cnt unchanged.
- **Halt:** halt_dec=1 -> DRAIN with pc_wen=0. A 2-cycle mstall during DRAIN extends the sequence; halted=1 after 3 non-stalled drain cycles, then all wen=0.
- **Reset/saturation:** assert rst asynchronously mid-MEM_WAIT -> outputs go to reset values immediately, then RUN. With CNT_W=2, 5 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: drives PC and pipeline-register enables/flushes
// for load-use bubbles, taken-branch flushes, data-memory waits and HLT drain.
module hazard_stall_ctrl #(
   parameter int CNT_W     = 16,
   parameter bit R0_HAZARD = 1'b0,
   parameter int DRAIN_CYC = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       ifid_rs,
   input  logic [3:0]       ifid_rt,
   input  logic             ifid_uses_rs,
   input  logic             ifid_uses_rt,
   input  logic             idex_memread,
   input  logic [3:0]       idex_rd,
   input  logic             branch_taken,
   input  logic             halt_dec,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_wen,
   output logic             ifid_wen,
   output logic             ifid_flush,
   output logic             idex_wen,
   output logic             idex_flush,
   output logic             exmem_wen,
   output logic             memwb_wen,
   output logic             memwb_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [2:0] {
      ST_RUN, ST_LU_BUBBLE, ST_MEM_WAIT, ST_DRAIN, ST_HALTED
   } state_t;

   localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYC - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [1:0]       r_drain_cnt;
   logic [1:0]       w_drain_next;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_stall_inc;
   logic             w_flush_inc;
   logic             w_rd_match;
   logic             w_lu_haz;
   logic             w_mstall;
   logic             w_freeze;

   assign w_rd_match = (ifid_uses_rs && (idex_rd == ifid_rs)) ||
                       (ifid_uses_rt && (idex_rd == ifid_rt));
   assign w_lu_haz   = idex_memread && w_rd_match && (R0_HAZARD || (idex_rd != 4'd0));
   assign w_mstall   = dmem_req & ~dmem_ready;
   // Once waiting, only the memory's ready releases the freeze.
   assign w_freeze   = (r_state == ST_MEM_WAIT) ? ~dmem_ready : w_mstall;

   // NOTE: every output and next-state signal gets a default at the top so no latch is inferred.
   always_comb begin
      pc_wen       = 1'b1;
      ifid_wen     = 1'b1;
      ifid_flush   = 1'b0;
      idex_wen     = 1'b1;
      idex_flush   = 1'b0;
      exmem_wen    = 1'b1;
      memwb_wen    = 1'b1;
      memwb_flush  = 1'b0;
      halted       = 1'b0;
      w_next_state = r_state;
      w_drain_next = r_drain_cnt;
      w_stall_inc  = 1'b0;
      w_flush_inc  = 1'b0;

      if (rst) begin
         pc_wen       = 1'b0;
         ifid_wen     = 1'b0;
         idex_wen     = 1'b0;
         exmem_wen    = 1'b0;
         memwb_wen    = 1'b0;
         w_next_state = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN, ST_LU_BUBBLE, ST_MEM_WAIT: begin
               if (w_freeze) begin
                  pc_wen       = 1'b0;
                  ifid_wen     = 1'b0;
                  idex_wen     = 1'b0;
                  exmem_wen    = 1'b0;
                  memwb_flush  = 1'b1;
                  w_stall_inc  = 1'b1;
                  w_next_state = ST_MEM_WAIT;
               end else if (halt_dec) begin
                  pc_wen       = 1'b0;
                  ifid_flush   = 1'b1;
                  w_drain_next = 2'd0;
                  w_next_state = ST_DRAIN;
               end else if (w_lu_haz) begin
                  pc_wen       = 1'b0;
                  ifid_wen     = 1'b0;
                  idex_flush   = 1'b1;
                  w_stall_inc  = 1'b1;
                  w_next_state = ST_LU_BUBBLE;
               end else if (branch_taken) begin
                  ifid_flush   = 1'b1;
                  w_flush_inc  = 1'b1;
                  w_next_state = ST_RUN;
               end else begin
                  w_next_state = ST_RUN;
               end
            end
            ST_DRAIN: begin
               pc_wen     = 1'b0;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               if (w_mstall) begin
                  exmem_wen   = 1'b0;
                  memwb_flush = 1'b1;
                  w_stall_inc = 1'b1;
               end else if (r_drain_cnt == DRAIN_LAST) begin
                  w_next_state = ST_HALTED;
               end else begin
                  w_drain_next = r_drain_cnt + 2'd1;
               end
            end
            ST_HALTED: begin
               pc_wen    = 1'b0;
               ifid_wen  = 1'b0;
               idex_wen  = 1'b0;
               exmem_wen = 1'b0;
               memwb_wen = 1'b0;
               halted    = 1'b1;
            end
            default: w_next_state = ST_RUN;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_drain_cnt <= 2'd0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_next_state;
         r_drain_cnt <= w_drain_next;
         if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}}))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule
